// File: rtl/alu_op_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer for 3-bit operands, 6-bit result.
// Ports: clk, rst_n, req_valid/req_ready/a/b/op in, res_valid/res_ready/res/err/busy out.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [1:0] op,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [2:0] a_q;
  logic [2:0] b_q;
  logic [1:0] op_q;
  logic [5:0] acc;
  logic [2:0] rem_q;
  logic [2:0] quo_q;

  logic [5:0] addend;
  logic [5:0] acc_nxt;
  logic       dvd_bit;
  logic [3:0] rem_sh;
  logic       ge;
  logic [2:0] rem_nxt;
  logic [2:0] quo_nxt;
  logic       last;

  always_comb begin
    addend  = '0;
    if (b_q[cnt])
      addend = {3'b000, a_q} << cnt;
    acc_nxt = acc + addend;
    dvd_bit = a_q[2'd2 - cnt];
    rem_sh  = {rem_q, dvd_bit};
    ge      = rem_sh >= {1'b0, b_q};
    // The difference always fits in 3 bits when ge holds.
    rem_nxt = ge ? (rem_sh[2:0] - b_q) : rem_sh[2:0];
    quo_nxt = {quo_q[1:0], ge};
    last    = cnt == 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      acc   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            acc   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt   <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          unique case (op_q)
            2'b00: begin
              res   <= {3'b000, a_q} + {3'b000, b_q};
              err   <= 1'b0;
              state <= DONE;
            end
            2'b01: begin
              res   <= {3'b000, a_q} - {3'b000, b_q};
              err   <= 1'b0;
              state <= DONE;
            end
            2'b10: begin
              acc <= acc_nxt;
              cnt <= cnt + 2'd1;
              if (last) begin
                res   <= acc_nxt;
                err   <= 1'b0;
                state <= DONE;
              end
            end
            2'b11: begin
              rem_q <= rem_nxt;
              quo_q <= quo_nxt;
              cnt   <= cnt + 2'd1;
              if (last) begin
                // Divide by zero still runs all steps, then overrides.
                if (b_q == 3'd0) begin
                  res <= {a_q, 3'b111};
                  err <= 1'b1;
                end else begin
                  res <= {rem_nxt, quo_nxt};
                  err <= 1'b0;
                end
                state <= DONE;
              end
            end
            default: state <= IDLE;
          endcase
        end
        DONE: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = state == IDLE;
  assign res_valid = state == DONE;
  assign busy      = state != IDLE;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer.
// Drives on negedge, samples on negedge, compares via immediate assertions.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] a = '0;
  logic [2:0] b = '0;
  logic [1:0] op = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [5:0] res;
  logic       err;
  logic       busy;

  typedef struct packed {
    logic [5:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int ta, input int tb, input int top);
    exp_t e;
    int   v;
    e.err = 1'b0;
    case (top)
      0: v = (ta + tb) % 64;
      1: v = (ta - tb + 64) % 64;
      2: v = ta * tb;
      default: begin
        if (tb == 0) begin
          v     = ta * 8 + 7;
          e.err = 1'b1;
        end else begin
          v = (ta % tb) * 8 + ta / tb;
        end
      end
    endcase
    e.res = 6'(v);
    return e;
  endfunction

  task automatic run_op(input int ta, input int tb, input int top,
                        input int lat, input int hold);
    exp_t e;
    int   n;
    chk("req_ready_idle", req_ready, 1);
    a         = 3'(ta);
    b         = 3'(tb);
    op        = 2'(top);
    req_valid = 1'b1;
    sb.push_back(model(ta, tb, top));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_exec", busy, 1);
    chk("req_ready_exec", req_ready, 0);
    n = 0;
    while (!res_valid && n < 8) begin
      req_valid = 1'($urandom_range(0, 1));
      a         = 3'($urandom);
      b         = 3'($urandom);
      op        = 2'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("latency", n, lat);
    chk("res_valid_done", res_valid, 1);
    e = sb.pop_front();
    chk("res", res, e.res);
    chk("err", err, e.err);
    repeat (hold) begin
      req_valid = 1'($urandom_range(0, 1));
      a         = 3'($urandom);
      b         = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("res_hold", res, e.res);
      chk("err_hold", err, e.err);
      chk("req_ready_hold", req_ready, 0);
      chk("res_valid_hold", res_valid, 1);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("req_ready_after_resp", req_ready, 1);
    chk("res_valid_after_resp", res_valid, 0);
    chk("busy_after_resp", busy, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(5, 6, 0, 1, 0);
    run_op(2, 5, 1, 1, 0);
    run_op(7, 7, 1, 1, 0);
    run_op(7, 7, 2, 3, 5);
    run_op(3, 0, 2, 3, 0);
    run_op(7, 2, 3, 3, 0);
    run_op(6, 3, 3, 3, 2);
    run_op(5, 0, 3, 3, 0);
    run_op(6, 5, 2, 3, 0);
    run_op(4, 7, 3, 3, 0);

    a         = 3'd7;
    b         = 3'd7;
    op        = 2'd2;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_res_valid", res_valid, 0);
      chk("post_rst_req_ready", req_ready, 1);
    end

    run_op(3, 4, 0, 1, 1);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
